// File: rtl/switch_debounce_bank.sv
// Sixteen-channel switch debouncer: 2-flop synchronizers, a shared sample-tick
// prescaler, per-channel tick-qualified stability counters, edge pulses and a selectable rise counter.
module switch_debounce_bank #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] swt,
  input  logic [3:0]  count_sel,
  input  logic        count_clr,
  output logic [15:0] swt_db,
  output logic [15:0] rise,
  output logic [15:0] fall,
  output logic [7:0]  count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   sync_meta;
  logic [15:0]   sync_lvl;
  logic [7:0]    stab_cnt [16];
  logic [7:0]    stab_nxt [16];
  logic [15:0]   toggle;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc     <= '0;
      sync_meta <= '0;
      sync_lvl  <= '0;
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      sync_meta <= swt;
      sync_lvl  <= sync_meta;
    end
  end

  // Any cycle at the current level restarts qualification; only tick cycles advance it.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < 16; i++) begin
      stab_nxt[i] = stab_cnt[i];
      if (sync_lvl[i] == swt_db[i]) begin
        stab_nxt[i] = '0;
      end else if (tick) begin
        if (stab_cnt[i] == 8'(STABLE_TICKS - 1)) begin
          toggle[i]   = 1'b1;
          stab_nxt[i] = '0;
        end else begin
          stab_nxt[i] = stab_cnt[i] + 8'd1;
        end
      end
    end
  end

  // NOTE: the stability counters are a small flop array, not a RAM, so they are
  // reset along with everything else to discard partial qualification.
  always_ff @(posedge clock) begin
    if (reset) begin
      swt_db <= '0;
      rise   <= '0;
      fall   <= '0;
      for (int i = 0; i < 16; i++) stab_cnt[i] <= '0;
    end else begin
      swt_db <= swt_db ^ toggle;
      rise   <= toggle & ~swt_db;
      fall   <= toggle & swt_db;
      for (int i = 0; i < 16; i++) stab_cnt[i] <= stab_nxt[i];
    end
  end

  // Clear wins over a coincident rise on the selected channel.
  always_ff @(posedge clock) begin
    if (reset || count_clr) begin
      count <= '0;
    end else if (rise[count_sel]) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Randomized and directed bench for switch_debounce_bank against a cycle-level
// behavioural model (TICK_DIV=4, STABLE_TICKS=3).
module tb_switch_debounce_bank;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] swt;
  logic [3:0]  count_sel;
  logic        count_clr;
  logic [15:0] swt_db, rise, fall;
  logic [7:0]  count;

  switch_debounce_bank #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clock(clock), .reset(reset), .swt(swt), .count_sel(count_sel),
    .count_clr(count_clr), .swt_db(swt_db), .rise(rise), .fall(fall), .count(count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: delayed input samples, accepted levels, ticks seen in
  // the current mismatch run, and cycles elapsed since reset released.
  logic [15:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_rise = '0, m_fall = '0;
  logic [7:0]  m_cnt = '0;
  int          m_run [16];
  int          m_since = 0;
  int          rise_tot [16];
  int          fall_tot [16];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [15:0] nd, nr, nf;
    logic        tk;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_cnt = '0;
      m_since = 0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
    end else begin
      tk = ((m_since % TD) == TD - 1);
      m_since++;
      nd = m_db; nr = '0; nf = '0;
      for (int i = 0; i < 16; i++) begin
        if (m_s2[i] == m_db[i]) m_run[i] = 0;
        else if (tk) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            m_run[i] = 0;
            nd[i] = ~m_db[i];
            if (nd[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
          end
        end
      end
      if (count_clr) m_cnt = '0;
      else if (m_rise[count_sel]) m_cnt = m_cnt + 8'd1;
      m_rise = nr; m_fall = nf; m_db = nd;
      m_s2 = m_s1; m_s1 = swt;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("swt_db", swt_db, m_db);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("count", count, m_cnt);
    check("rise_fall_excl", rise & fall, 0);
    for (int i = 0; i < 16; i++) begin
      if (rise[i]) rise_tot[i]++;
      if (fall[i]) fall_tot[i]++;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  initial begin
    int lat, changes, r0, f0, found;
    logic [7:0]  c0;
    logic        prev;
    logic [31:0] mask;

    for (int i = 0; i < 16; i++) begin m_run[i] = 0; rise_tot[i] = 0; fall_tot[i] = 0; end
    reset = 1'b1; swt = '0; count_sel = '0; count_clr = 1'b0;
    hold(3);
    check("reset_db", swt_db, 0);
    check("reset_count", count, 0);
    reset = 1'b0;
    hold(4);

    // Single clean step on channel 0, counted.
    r0 = rise_tot[0];
    swt[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (lat == 0 && swt_db[0]) lat = k;
    end
    check("step_latency_in_11_14", (lat >= 11 && lat <= 14), 1);
    check("step_rise_once", rise_tot[0] - r0, 1);
    check("step_count_1", count, 1);

    // Bounce that never holds long enough, then a real hold.
    swt[0] = 1'b0;
    hold(30);
    changes = 0;
    prev = swt_db[0];
    for (int c = 0; c < 20; c++) begin
      swt[0] = ((c / 3) % 2 == 0);
      step();
      if (swt_db[0] != prev) changes++;
      prev = swt_db[0];
    end
    check("bounce_no_change", changes, 0);
    c0 = count; r0 = rise_tot[0];
    swt[0] = 1'b1;
    hold(30);
    check("bounce_one_rise", rise_tot[0] - r0, 1);
    check("bounce_count_inc", count, 8'(c0 + 8'd1));

    // 256 presses on channel 5 wrap the counter; channel 6 must not touch it.
    count_sel = 4'd5;
    count_clr = 1'b1; step(); count_clr = 1'b0;
    r0 = rise_tot[5]; f0 = fall_tot[5];
    repeat (256) begin
      swt[5] = 1'b1; hold(16);
      swt[5] = 1'b0; hold(16);
    end
    check("wrap_count_0", count, 0);
    check("wrap_rises_256", rise_tot[5] - r0, 256);
    check("wrap_falls_256", fall_tot[5] - f0, 256);
    swt[5] = 1'b1; hold(16);
    c0 = count;
    r0 = rise_tot[6];
    repeat (256) begin
      swt[6] = 1'b1; hold(16);
      swt[6] = 1'b0; hold(16);
    end
    check("unselected_rises_256", rise_tot[6] - r0, 256);
    check("unselected_count_same", count, c0);
    swt[5] = 1'b0; hold(16);

    // Clear coincident with a selected rise.
    count_sel = 4'd3;
    count_clr = 1'b1; step(); count_clr = 1'b0;
    repeat (7) begin
      swt[3] = 1'b1; hold(16);
      swt[3] = 1'b0; hold(16);
    end
    check("clr_pre_count_7", count, 7);
    swt[3] = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (rise[3]) found = 1;
    end
    check("clr_rise3_seen", found, 1);
    count_clr = 1'b1; step(); count_clr = 1'b0;
    check("clr_priority_count_0", count, 0);

    // All channels stepped together.
    swt = '0;
    hold(30);
    swt = 16'hFFFF;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (rise != 0) begin
        found = 1;
        check("all_rise_same_cycle", rise, 16'hFFFF);
        check("all_db_ffff", swt_db, 16'hFFFF);
      end
    end
    check("all_rise_seen", found, 1);

    // Reset after two of three qualifying ticks discards the progress.
    swt = '0;
    hold(30);
    swt[2] = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (m_run[2] == 2) found = 1;
    end
    check("partial_qual_reached", found, 1);
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 11) check("rst_mid_db2_still_0", swt_db[2], 0);
      if (k == 14) check("rst_mid_db2_now_1", swt_db[2], 1);
    end

    // Randomized traffic with varying bounce density.
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < 500; c++) begin
        mask = $urandom;
        for (int d = 0; d < 2 + blk % 4; d++) mask = mask & $urandom;
        swt = swt ^ mask[15:0];
        if (c % 64 == 0) count_sel = 4'($urandom_range(0, 15));
        count_clr = ($urandom_range(0, 49) == 0);
        reset = ($urandom_range(0, 999) == 0);
        step();
      end
    end
    reset = 1'b0; count_clr = 1'b0;
    hold(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
